// File: rtl/xor_unit_arbiter.sv
// xor_unit_arbiter
//   Shares a single NOR-built 1-bit XOR cell among NREQ requesters. A round-robin arbiter
//   grants one requester at a time. The granted operands are latched and pushed through the
//   cell one bit per clock. Completion is signalled with a one-cycle ack/valid pulse.
//
//   Optional feature macro: XOR_ARB_PARITY_EN adds parity_o (even parity of res_o).
//
// Ports
//   clk        clock, all state updates on posedge
//   reset      synchronous active-high reset
//   req_i      per-requester level request, held until ack
//   a_i, b_i   packed operands, requester k at [k*WIDTH +: WIDTH]
//   ack_o      one-hot, one-cycle completion pulse to the served requester
//   busy_o     high while an operation is in flight (SHIFT/DONE)
//   gnt_idx_o  index of the current / most recently granted requester
//   res_o      A^B of the last completed operation (never partial)
//   valid_o    one-cycle pulse coincident with ack_o
//   parity_o   ^res_o, updated together with res_o (XOR_ARB_PARITY_EN only)

module xor_unit_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] a_i,
    input  logic [NREQ*WIDTH-1:0] b_i,
    output logic [NREQ-1:0]       ack_o,
    output logic                  busy_o,
    output logic [IW-1:0]         gnt_idx_o,
    output logic [WIDTH-1:0]      res_o,
    output logic                  valid_o
`ifdef XOR_ARB_PARITY_EN
    ,
    output logic                  parity_o
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);
    localparam logic [IW-1:0] IdxLast = IW'(NREQ - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_op_q, a_op_d;
    logic [WIDTH-1:0]  b_op_q, b_op_d;
    logic [WIDTH-1:0]  res_sh_q, res_sh_d;
    logic [IW-1:0]     gnt_q, gnt_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
`ifdef XOR_ARB_PARITY_EN
    logic              acc_q, acc_d;
    logic              parity_q, parity_d;
`endif

    // ------------------------------------------------------------------
    // The one shared XOR cell, built from four NOR gates plus an inverter
    // (NOR with both inputs tied). Every result bit passes through here.
    // ------------------------------------------------------------------
    logic a_bit, b_bit;
    logic nor_ab, nor_a, nor_b, xnor_ab, cell_out;

    assign a_bit    = a_op_q[cnt_q];
    assign b_bit    = b_op_q[cnt_q];
    assign nor_ab   = ~(a_bit | b_bit);
    assign nor_a    = ~(a_bit | nor_ab);
    assign nor_b    = ~(b_bit | nor_ab);
    assign xnor_ab  = ~(nor_a | nor_b);
    assign cell_out = ~(xnor_ab | xnor_ab);

    // ------------------------------------------------------------------
    // Round-robin pick: lowest requester at or above ptr, else lowest
    // overall (the wrap-around case).
    // ------------------------------------------------------------------
    logic [NREQ-1:0] hi_req;
    logic [IW-1:0]   hi_idx, lo_idx, win_idx;

    always_comb begin
        hi_req = '0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            hi_req[i] = req_i[i] && (IW'(i) >= ptr_q);
        end
        // Scan downwards so the last hit is the lowest index.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (hi_req[i]) hi_idx = IW'(i);
            if (req_i[i])  lo_idx = IW'(i);
        end
        win_idx = (|hi_req) ? hi_idx : lo_idx;
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        a_op_d   = a_op_q;
        b_op_d   = b_op_q;
        res_sh_d = res_sh_q;
        gnt_d    = gnt_q;
        res_d    = res_q;
        ack_d    = '0;
        valid_d  = 1'b0;
        busy_d   = busy_q;
`ifdef XOR_ARB_PARITY_EN
        acc_d    = acc_q;
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (|req_i) begin
                    a_op_d   = a_i[32'(win_idx) * WIDTH +: WIDTH];
                    b_op_d   = b_i[32'(win_idx) * WIDTH +: WIDTH];
                    res_sh_d = '0;
                    gnt_d    = win_idx;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
`ifdef XOR_ARB_PARITY_EN
                    acc_d    = 1'b0;
`endif
                    state_d  = StShift;
                end
            end
            StShift: begin
                res_sh_d[cnt_q] = cell_out;
`ifdef XOR_ARB_PARITY_EN
                acc_d = acc_q ^ cell_out;
`endif
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                res_d   = res_sh_q;
                ack_d   = NREQ'(1) << gnt_q;
                valid_d = 1'b1;
                ptr_d   = (gnt_q == IdxLast) ? '0 : gnt_q + 1'b1;
                busy_d  = 1'b0;
`ifdef XOR_ARB_PARITY_EN
                parity_d = acc_q;
`endif
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            cnt_q    <= '0;
            a_op_q   <= '0;
            b_op_q   <= '0;
            res_sh_q <= '0;
            gnt_q    <= '0;
            res_q    <= '0;
            ack_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef XOR_ARB_PARITY_EN
            acc_q    <= 1'b0;
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            a_op_q   <= a_op_d;
            b_op_q   <= b_op_d;
            res_sh_q <= res_sh_d;
            gnt_q    <= gnt_d;
            res_q    <= res_d;
            ack_q    <= ack_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
`ifdef XOR_ARB_PARITY_EN
            acc_q    <= acc_d;
            parity_q <= parity_d;
`endif
        end
    end

    assign ack_o     = ack_q;
    assign busy_o    = busy_q;
    assign gnt_idx_o = gnt_q;
    assign res_o     = res_q;
    assign valid_o   = valid_q;
`ifdef XOR_ARB_PARITY_EN
    assign parity_o  = parity_q;
`endif

endmodule

// File: tb/tb_xor_unit_arbiter.sv
// Testbench for xor_unit_arbiter: directed scenarios followed by randomized request patterns
// and operands, checked against a transaction-level model (round-robin pick over the request
// vector, result = A ^ B, fixed WIDTH+2 cycle completion).

module tb_xor_unit_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_bus;
    logic [NREQ*WIDTH-1:0] b_bus;
    logic [NREQ-1:0]       ack;
    logic                  busy;
    logic [1:0]            gnt;
    logic [WIDTH-1:0]      res;
    logic                  valid;
`ifdef XOR_ARB_PARITY_EN
    logic                  parity;
`endif

    int               n_checks;
    int               n_fail;
    int               ref_ptr;
    logic [WIDTH-1:0] prev_res;

    xor_unit_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req),
        .a_i       (a_bus),
        .b_i       (b_bus),
        .ack_o     (ack),
        .busy_o    (busy),
        .gnt_idx_o (gnt),
        .res_o     (res),
        .valid_o   (valid)
`ifdef XOR_ARB_PARITY_EN
        ,
        .parity_o  (parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference arbitration: first requester at or after ptr, wrapping.
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return 0;
    endfunction

    task automatic set_op(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        a_bus[k*WIDTH +: WIDTH] = a;
        b_bus[k*WIDTH +: WIDTH] = b;
    endtask

    task automatic scramble();
        for (int k = 0; k < NREQ; k++) begin
            set_op(k, WIDTH'($urandom), WIDTH'($urandom));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, ".ack"}, 32'(ack), 0);
        check_eq({tag, ".busy"}, 32'(busy), 0);
        check_eq({tag, ".gnt"}, 32'(gnt), 0);
        check_eq({tag, ".res"}, 32'(res), 0);
        check_eq({tag, ".valid"}, 32'(valid), 0);
`ifdef XOR_ARB_PARITY_EN
        check_eq({tag, ".parity"}, 32'(parity), 0);
`endif
        ref_ptr  = 0;
        prev_res = '0;
    endtask

    task automatic do_reset();
        req   = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("reset");
    endtask

    // Called on a negedge with req already driven; the DUT must be idle at the next posedge.
    // Waits for the ack and checks the whole completed transaction against the model.
    task automatic expect_op(input string tag, input bit scr, output int widx);
        int               lat;
        bit               hold_bad;
        logic             busy_seen;
        logic [WIDTH-1:0] exp_res;
        widx      = pick(req, ref_ptr);
        exp_res   = a_bus[widx*WIDTH +: WIDTH] ^ b_bus[widx*WIDTH +: WIDTH];
        lat       = 0;
        hold_bad  = 1'b0;
        busy_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                busy_seen = busy;
                // Operands were latched at grant; changing them now must not matter.
                if (scr) scramble();
            end
            if (ack == '0 && res !== prev_res) hold_bad = 1'b1;
        end while (ack == '0 && lat < 4 * WIDTH + 8);
        check_eq({tag, ".latency"}, 32'(lat), 32'(WIDTH + 2));
        check_eq({tag, ".busy_run"}, 32'(busy_seen), 1);
        check_eq({tag, ".res_hold"}, 32'(hold_bad), 0);
        check_eq({tag, ".ack"}, 32'(ack), 32'(1) << widx);
        check_eq({tag, ".valid"}, 32'(valid), 1);
        check_eq({tag, ".busy_done"}, 32'(busy), 0);
        check_eq({tag, ".gnt"}, 32'(gnt), 32'(widx));
        check_eq({tag, ".res"}, 32'(res), 32'(exp_res));
`ifdef XOR_ARB_PARITY_EN
        check_eq({tag, ".parity"}, 32'(parity), 32'(^exp_res));
`endif
        ref_ptr  = (widx + 1) % NREQ;
        prev_res = exp_res;
    endtask

    initial begin
        int w;
        n_checks = 0;
        n_fail   = 0;
        req      = '0;
        a_bus    = '0;
        b_bus    = '0;
        reset    = 1'b1;
        ref_ptr  = 0;
        prev_res = '0;
        do_reset();

        // Single request, known operands.
        set_op(0, 8'hA5, 8'h0F);
        req = 4'b0001;
        expect_op("t1", 1'b1, w);

        // Cell truth-table coverage and parity values.
        set_op(1, 8'hF0, 8'hCC);
        req = 4'b0010;
        expect_op("t4a", 1'b0, w);
        set_op(2, 8'hFF, 8'hFF);
        req = 4'b0100;
        expect_op("t4b", 1'b0, w);
        set_op(3, 8'h00, 8'hFF);
        req = 4'b1000;
        expect_op("t4c", 1'b0, w);
        set_op(0, 8'h01, 8'h00);
        req = 4'b0001;
        expect_op("t6", 1'b0, w);

        // All four requesting, each drops on its own ack.
        do_reset();
        scramble();
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            expect_op("t2", 1'b1, w);
            req[w] = 1'b0;
        end

        // Requester 2 alone, then everyone held continuously.
        req = 4'b0100;
        expect_op("t3a", 1'b1, w);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            expect_op("t3b", 1'b1, w);
        end

        // Reset in the middle of an operation on requester 1.
        req = 4'b0001;
        expect_op("t5pre", 1'b1, w);
        req = 4'b0010;
        repeat (4) @(negedge clk);
        check_eq("t5.no_ack_before", 32'(ack), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state("t5");
        req = 4'b0011;
        expect_op("t5next", 1'b1, w);

        // Randomized request patterns with occasional idle gaps.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(3) == 0) begin
                req = '0;
                repeat ($urandom_range(3, 1)) begin
                    @(negedge clk);
                    check_eq("idle.ack", 32'(ack), 0);
                    check_eq("idle.busy", 32'(busy), 0);
                end
            end
            req = NREQ'($urandom_range(15, 1));
            expect_op("rnd", 1'b1, w);
        end

        req = '0;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
